// File: rtl/timer_pkg.sv
// Shared constants for the down-counting timer: register map,
// CTRL bit positions and the timer state encoding.
package timer_pkg;

  localparam int unsigned REG_CTRL     = 0;
  localparam int unsigned REG_LOAD     = 1;
  localparam int unsigned REG_COUNT    = 2;
  localparam int unsigned REG_STATUS   = 3;
  localparam int unsigned REG_PRESCALE = 4;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_PER = 1;
  localparam int unsigned CTRL_IE  = 2;

  localparam int unsigned PSC_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/timer_counter_if.sv
// Single-cycle register bus between the load/store path and the
// timer: write strobe, address, data, combinational read, irq.
interface timer_counter_if #(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 3
);

  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  wdata;
  logic [CNT_W-1:0]  rd_data;
  logic              irq;

  modport master (
    output wr_en,
    output addr,
    output wdata,
    input  rd_data,
    input  irq
  );

  modport slave (
    input  wr_en,
    input  addr,
    input  wdata,
    output rd_data,
    output irq
  );

endinterface

// File: rtl/tick_edge_detect.sv
// Turns the T flip-flop toggle output into a one-clock pulse
// on each rising edge.
module tick_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic tick_o
);

  logic tick_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_in;
    end
  end

  assign tick_o = tick_in & ~tick_q;

endmodule

// File: rtl/timer_counter.sv
// Programmable down-counting timer with sticky expiry flag and irq.
// Optional PRESCALE register enabled by defining TIMER_PRESCALE_EN.
module timer_counter
  import timer_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick_in,
  timer_counter_if.slave  bus
);

  state_e           state_q, state_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flag_q, flag_d;
  logic             irq_q, irq_d;

  logic             tick;
  logic             eff_tick;
  logic             reload;
  logic             wr_ctrl;
  logic             wr_load;
  logic             wr_stat;
  logic             stop;
  logic [CNT_W-1:0] rd;

  tick_edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .tick_in (tick_in),
    .tick_o  (tick)
  );

  assign wr_ctrl = bus.wr_en && (bus.addr == ADDR_W'(REG_CTRL));
  assign wr_load = bus.wr_en && (bus.addr == ADDR_W'(REG_LOAD));
  assign wr_stat = bus.wr_en && (bus.addr == ADDR_W'(REG_STATUS));
  assign stop    = wr_ctrl && !bus.wdata[CTRL_EN];

`ifdef TIMER_PRESCALE_EN
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [PSC_W-1:0] pcnt_q, pcnt_d;
  logic             wr_psc;

  assign wr_psc   = bus.wr_en && (bus.addr == ADDR_W'(REG_PRESCALE));
  assign eff_tick = tick && (pcnt_q == psc_q);
`else
  assign eff_tick = tick;
`endif

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    flag_d  = flag_q;
    reload  = 1'b0;

    if (wr_load) begin
      load_d = bus.wdata;
    end
    if (wr_stat && bus.wdata[0]) begin
      flag_d = 1'b0;
    end

    if (wr_ctrl) begin
      ctrl_d = bus.wdata[2:0];
      if (!bus.wdata[CTRL_EN]) begin
        state_d = IDLE;
      end else if (state_q != RUN) begin
        count_d = load_q;
        state_d = RUN;
        reload  = 1'b1;
      end
    end

    // expiry is evaluated after the W1C so a same-cycle set wins
    if (state_q == RUN && eff_tick && !stop) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        flag_d = 1'b1;
        if (ctrl_q[CTRL_PER]) begin
          count_d = load_q;
          reload  = 1'b1;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = DONE;
        end
      end
    end

    irq_d = flag_q & ctrl_q[CTRL_IE];
  end

`ifdef TIMER_PRESCALE_EN
  always_comb begin
    psc_d  = psc_q;
    pcnt_d = pcnt_q;
    if (wr_psc) begin
      psc_d = bus.wdata[PSC_W-1:0];
    end
    if (state_q == RUN && tick) begin
      pcnt_d = eff_tick ? '0 : pcnt_q + PSC_W'(1);
    end
    if (reload) begin
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q  <= '0;
      pcnt_q <= '0;
    end else begin
      psc_q  <= psc_d;
      pcnt_q <= pcnt_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      flag_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      flag_q  <= flag_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    rd = '0;
    unique case (bus.addr)
      ADDR_W'(REG_CTRL):     rd = CNT_W'(ctrl_q);
      ADDR_W'(REG_LOAD):     rd = load_q;
      ADDR_W'(REG_COUNT):    rd = count_q;
      ADDR_W'(REG_STATUS):   rd = CNT_W'(flag_q);
`ifdef TIMER_PRESCALE_EN
      ADDR_W'(REG_PRESCALE): rd = CNT_W'(psc_q);
`endif
      default:               rd = '0;
    endcase
  end

  assign bus.rd_data = rd;
  assign bus.irq     = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: stimulus queues expected
// read/irq values, a negedge monitor pops and compares them.
module tb_timer_counter;

  localparam int CNT_W  = 32;
  localparam int ADDR_W = 3;

  logic clk;
  logic rst;
  logic tick_in;
  logic chk;

  timer_counter_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();

  timer_counter #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .tick_in (tick_in),
    .bus     (bus)
  );

  logic [CNT_W-1:0] exp_rd_q[$];
  int               exp_irq_q[$];
  string            name_q[$];

  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk) begin
      if (exp_rd_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_empty: monitor saw a check with no expectation");
      end else begin
        logic [CNT_W-1:0] e;
        int               ei;
        string            nm;
        e  = exp_rd_q.pop_front();
        ei = exp_irq_q.pop_front();
        nm = name_q.pop_front();
        vectors++;
        if (bus.rd_data !== e) begin
          miscompares++;
          $display("FAIL %s rd_data: got %0h expected %0h",
                   nm, bus.rd_data, e);
        end
        if (ei != 2) begin
          vectors++;
          if (bus.irq !== ei[0]) begin
            miscompares++;
            $display("FAIL %s irq: got %0b expected %0b",
                     nm, bus.irq, ei[0]);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [CNT_W-1:0] d);
    bus.wr_en = 1'b1;
    bus.addr  = ADDR_W'(a);
    bus.wdata = d;
    cyc();
    bus.wr_en = 1'b0;
  endtask

  task automatic tick();
    tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
    cyc();
  endtask

  // irq expectation 2 means don't care
  task automatic check(input int a, input logic [CNT_W-1:0] e,
                       input int ei, input string nm);
    bus.addr = ADDR_W'(a);
    exp_rd_q.push_back(e);
    exp_irq_q.push_back(ei);
    name_q.push_back(nm);
    chk = 1'b1;
    @(negedge clk);
    #1;
    chk = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    tick_in   = 1'b0;
    chk       = 1'b0;
    bus.wr_en = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (3) cyc();
    rst = 1'b0;

    check(0, 0, 0, "rst_ctrl");
    check(1, 0, 2, "rst_load");
    check(2, 0, 2, "rst_count");
    check(3, 0, 0, "rst_status");
    check(4, 0, 2, "rst_addr4");
    check(5, 0, 2, "rst_addr5");

    // one-shot, LOAD=3: expiry on the fourth tick
    wr(1, 3);
    wr(0, 32'h1);
    check(2, 3, 0, "os_start");
    tick();
    check(2, 2, 2, "os_c2");
    tick();
    check(2, 1, 2, "os_c1");
    tick();
    check(2, 0, 2, "os_c0");
    check(3, 0, 2, "os_noflag");
    tick();
    check(3, 1, 0, "os_flag");
    check(0, 0, 2, "os_en_clr");
    tick();
    check(2, 0, 2, "os_done_hold");
    wr(3, 1);
    check(3, 0, 0, "os_w1c");

    // periodic with irq, LOAD=2
    wr(1, 2);
    wr(0, 32'h7);
    check(2, 2, 0, "per_start");
    tick();
    check(2, 1, 2, "per_c1");
    tick();
    check(2, 0, 2, "per_c0");
    tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
    check(3, 1, 0, "per_flag_irq_lag");
    cyc();
    check(2, 2, 1, "per_reload_irq");
    tick();
    check(2, 1, 2, "per2_c1");
    tick();
    check(2, 0, 2, "per2_c0");

    // W1C in the expiry cycle: set wins
    bus.wr_en = 1'b1;
    bus.addr  = ADDR_W'(3);
    bus.wdata = 1;
    tick_in   = 1'b1;
    cyc();
    bus.wr_en = 1'b0;
    tick_in   = 1'b0;
    check(3, 1, 1, "w1c_set_wins");
    cyc();
    check(2, 2, 1, "w1c_reload");
    wr(3, 1);
    check(3, 0, 1, "w1c_clr_irq_lag");
    cyc();
    check(3, 0, 0, "w1c_irq_drop");

    // en=1 CTRL write while running: no reload; clearing ie
    tick();
    tick();
    tick();
    check(3, 1, 2, "ie_flag_set");
    tick();
    wr(0, 32'h3);
    check(2, 1, 1, "ctrl_no_reload");
    cyc();
    check(3, 1, 0, "ie_clr_flag_kept");

    // LOAD written mid-run applies at next reload
    wr(3, 1);
    wr(0, 0);
    wr(1, 5);
    wr(0, 32'h3);
    wr(1, 9);
    check(2, 5, 2, "ld_start");
    for (int i = 4; i >= 0; i--) begin
      tick();
      check(2, CNT_W'(i), 2, "ld_countdown");
    end
    tick();
    check(2, 9, 0, "ld_reload_new");
    check(3, 1, 0, "ld_flag");
    tick();
    wr(0, 0);
    tick();
    check(2, 8, 2, "dis_frozen");
    check(0, 0, 2, "dis_ctrl");
    check(3, 1, 2, "dis_flag_kept");

    // tick coincident with en 0->1 is ignored
    wr(1, 4);
    bus.wr_en = 1'b1;
    bus.addr  = ADDR_W'(0);
    bus.wdata = 1;
    tick_in   = 1'b1;
    cyc();
    bus.wr_en = 1'b0;
    tick_in   = 1'b0;
    cyc();
    check(2, 4, 2, "start_tick_ignored");

    // synchronous reset mid-count
    wr(0, 0);
    wr(1, 6);
    wr(0, 32'h7);
    cyc();
    check(2, 6, 1, "pre_rst");
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check(0, 0, 0, "mid_rst_ctrl");
    check(1, 0, 2, "mid_rst_load");
    check(2, 0, 2, "mid_rst_count");
    check(3, 0, 2, "mid_rst_status");
    tick();
    check(2, 0, 0, "mid_rst_tick_ign");

    // LOAD=0 expires on every tick
    wr(0, 32'h3);
    tick();
    check(3, 1, 2, "l0_exp1");
    wr(3, 1);
    check(3, 0, 2, "l0_clr");
    tick();
    check(3, 1, 2, "l0_exp2");
    check(2, 0, 2, "l0_count");

    // unmapped addresses
    wr(6, 32'hFFFF_FFFF);
    check(6, 0, 2, "unmapped6");
    check(7, 0, 2, "unmapped7");

`ifdef TIMER_PRESCALE_EN
    wr(3, 1);
    wr(0, 0);
    wr(4, 1);
    check(4, 1, 2, "psc_read");
    wr(1, 1);
    wr(0, 32'h3);
    tick();
    tick();
    tick();
    check(3, 0, 2, "psc_3ticks");
    tick();
    check(3, 1, 2, "psc_4ticks");
`else
    wr(4, 32'hFF);
    check(4, 0, 2, "psc_absent");
`endif

    repeat (2) cyc();
    if (exp_rd_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d pending expected 0",
               exp_rd_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
